// File: rtl/tdc_corr_sched.sv
// tdc_corr_sched: walks an inclusive TDC sample address range. For each sample it
// reads the rise data, launches the correction datapath, waits for the result and
// writes it back.
// Optional build macro TDC_CORR_TIMEOUT_EN adds a bounded wait on the datapath.
// A sample that times out is written as all-ones and raises a sticky error flag.
module tdc_corr_sched #(
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 31
) (
  input  logic              i_clk_50m,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_addr_first,
  input  logic [ADDR_W-1:0] i_addr_last,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_ram_rd_en,
  output logic [ADDR_W-1:0] o_ram_rd_addr,
  input  logic [DATA_W-1:0] i_ram_rd_data,
  output logic [ADDR_W-1:0] o_tdc_rd_addr,
  output logic [DATA_W-1:0] o_rise_data,
  output logic              o_process_en,
  input  logic              i_process_done,
  input  logic [DATA_W-1:0] i_process_data,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic [ADDR_W:0]   o_sample_cnt,
  output logic              o_err_timeout
);

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StRdWait,
    StLaunch,
    StWaitDone,
    StWrite,
    StNext,
    StDone
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] cur_q;
  logic [ADDR_W-1:0] last_q;

`ifdef TDC_CORR_TIMEOUT_EN
  localparam int unsigned ToW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [ToW-1:0] to_cnt_q;
`else
  // TIMEOUT only matters when the bounded datapath wait is built in.
  assign o_err_timeout = 1'b0 & (TIMEOUT != 0);
`endif

  // Frame sequencer: state and every output register advance together.
  always_ff @(posedge i_clk_50m) begin
    if (!i_rst_n) begin
      state_q       <= StIdle;
      cur_q         <= '0;
      last_q        <= '0;
      o_busy        <= 1'b0;
      o_frame_done  <= 1'b0;
      o_ram_rd_en   <= 1'b0;
      o_ram_rd_addr <= '0;
      o_tdc_rd_addr <= '0;
      o_rise_data   <= '0;
      o_process_en  <= 1'b0;
      o_wr_en       <= 1'b0;
      o_wr_addr     <= '0;
      o_wr_data     <= '0;
      o_sample_cnt  <= '0;
`ifdef TDC_CORR_TIMEOUT_EN
      to_cnt_q      <= '0;
      o_err_timeout <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          o_frame_done <= 1'b0;
          if (o_frame_done) begin
            // Frame-done cycle just ended; busy covers it, so any start here is dropped.
            o_busy <= 1'b0;
          end else if (i_start && !o_busy) begin
            o_busy       <= 1'b1;
            cur_q        <= i_addr_first;
            last_q       <= i_addr_last;
            o_sample_cnt <= '0;
`ifdef TDC_CORR_TIMEOUT_EN
            o_err_timeout <= 1'b0;
`endif
            if (i_addr_first > i_addr_last) begin
              state_q <= StDone;
            end else begin
              o_ram_rd_en   <= 1'b1;
              o_ram_rd_addr <= i_addr_first;
              state_q       <= StRd;
            end
          end
        end
        StRd: begin
          o_ram_rd_en <= 1'b0;
          state_q     <= StRdWait;
        end
        StRdWait: begin
          // RAM data for the read issued in StRd is valid now.
          o_rise_data   <= i_ram_rd_data;
          o_tdc_rd_addr <= cur_q;
          o_process_en  <= 1'b1;
          state_q       <= StLaunch;
        end
        StLaunch: begin
          o_process_en <= 1'b0;
`ifdef TDC_CORR_TIMEOUT_EN
          to_cnt_q     <= '0;
`endif
          state_q      <= StWaitDone;
        end
        StWaitDone: begin
          if (i_process_done) begin
            o_wr_en      <= 1'b1;
            o_wr_addr    <= cur_q;
            o_wr_data    <= i_process_data;
            o_sample_cnt <= o_sample_cnt + 1'b1;
            state_q      <= StWrite;
`ifdef TDC_CORR_TIMEOUT_EN
          end else if (to_cnt_q == ToW'(TIMEOUT - 1)) begin
            // No answer from the datapath: poison the sample and move on.
            o_wr_en       <= 1'b1;
            o_wr_addr     <= cur_q;
            o_wr_data     <= '1;
            o_sample_cnt  <= o_sample_cnt + 1'b1;
            o_err_timeout <= 1'b1;
            state_q       <= StWrite;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
`endif
          end
        end
        StWrite: begin
          o_wr_en <= 1'b0;
          state_q <= StNext;
        end
        StNext: begin
          // Equality test ends the frame before cur can wrap at the top address.
          if (cur_q == last_q) begin
            state_q <= StDone;
          end else begin
            cur_q         <= cur_q + 1'b1;
            o_ram_rd_en   <= 1'b1;
            o_ram_rd_addr <= cur_q + 1'b1;
            state_q       <= StRd;
          end
        end
        StDone: begin
          // Done pulse is registered out of this state and lands in the next cycle.
          o_frame_done <= 1'b1;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_corr_sched.sv
// Bench for tdc_corr_sched: RAM and datapath models plus a write scoreboard.
// Build with TDC_CORR_TIMEOUT_EN to add the timeout sequence.
`timescale 1ns/1ps
module tb_tdc_corr_sched;
  localparam int unsigned ADDR_W  = 11;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned TIMEOUT = 31;

  logic              i_clk_50m = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_start = 1'b0;
  logic [ADDR_W-1:0] i_addr_first = '0;
  logic [ADDR_W-1:0] i_addr_last = '0;
  logic              o_busy;
  logic              o_frame_done;
  logic              o_ram_rd_en;
  logic [ADDR_W-1:0] o_ram_rd_addr;
  logic [DATA_W-1:0] i_ram_rd_data = '0;
  logic [ADDR_W-1:0] o_tdc_rd_addr;
  logic [DATA_W-1:0] o_rise_data;
  logic              o_process_en;
  logic              i_process_done = 1'b0;
  logic [DATA_W-1:0] i_process_data = '0;
  logic              o_wr_en;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [DATA_W-1:0] o_wr_data;
  logic [ADDR_W:0]   o_sample_cnt;
  logic              o_err_timeout;

  tdc_corr_sched #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk_50m     (i_clk_50m),
    .i_rst_n       (i_rst_n),
    .i_start       (i_start),
    .i_addr_first  (i_addr_first),
    .i_addr_last   (i_addr_last),
    .o_busy        (o_busy),
    .o_frame_done  (o_frame_done),
    .o_ram_rd_en   (o_ram_rd_en),
    .o_ram_rd_addr (o_ram_rd_addr),
    .i_ram_rd_data (i_ram_rd_data),
    .o_tdc_rd_addr (o_tdc_rd_addr),
    .o_rise_data   (o_rise_data),
    .o_process_en  (o_process_en),
    .i_process_done(i_process_done),
    .i_process_data(i_process_data),
    .o_wr_en       (o_wr_en),
    .o_wr_addr     (o_wr_addr),
    .o_wr_data     (o_wr_data),
    .o_sample_cnt  (o_sample_cnt),
    .o_err_timeout (o_err_timeout)
  );

  always #10 i_clk_50m = ~i_clk_50m;

  int unsigned cyc = 0;
  always @(posedge i_clk_50m) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] ram_f(input logic [ADDR_W-1:0] a);
    return 16'(a * 16'd37 + 16'h1234);
  endfunction

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;
  wr_t exp_q[$];

  // Model / monitor state
  int                n_rd = 0, n_wr = 0, n_done = 0;
  int                dp_lat = 4, dp_cnt = 0;
  logic [ADDR_W-1:0] dp_addr = '0;
  logic [DATA_W-1:0] dp_rise = '0;
  bit                dead_en = 1'b0;
  logic [ADDR_W-1:0] dead_addr = '0;
  int                stray_cnt = 0;
  bit                ram_pend = 1'b0;
  logic [ADDR_W-1:0] ram_addr = '0;
  int unsigned       start_cyc = 0, last_pen = 0, done_cyc = 0;
  int                frame_pens = 0;
  bit                prev_done = 1'b0;

  // RAM, datapath and write-port models, sampled mid-cycle.
  always @(negedge i_clk_50m) begin
    if (ram_pend) begin
      i_ram_rd_data = ram_f(ram_addr);
      ram_pend = 1'b0;
    end else begin
      i_ram_rd_data = 16'hBAD0 ^ 16'(cyc);
    end
    if (o_ram_rd_en) begin
      ram_pend = 1'b1;
      ram_addr = o_ram_rd_addr;
      n_rd++;
    end

    i_process_done = 1'b0;
    if (!i_rst_n) dp_cnt = 0;
    if (dp_cnt != 0) begin
      check("operand_hold", {o_tdc_rd_addr, o_rise_data}, {dp_addr, dp_rise});
      dp_cnt--;
      if (dp_cnt == 0 && !(dead_en && dp_addr == dead_addr)) begin
        i_process_done = 1'b1;
        i_process_data = dp_rise + 16'd1;
      end
    end
    if (stray_cnt != 0 && o_ram_rd_en && !i_process_done) begin
      i_process_done = 1'b1;
      i_process_data = 16'hDEAD;
      stray_cnt--;
    end

    if (o_process_en) begin
      check("rise_data", o_rise_data, ram_f(o_tdc_rd_addr));
      if (frame_pens == 0) check("first_launch_cyc", cyc, start_cyc + 3);
      else if (!dead_en) check("launch_gap", cyc - last_pen, dp_lat + 5);
      last_pen = cyc;
      frame_pens++;
      dp_cnt = dp_lat;
      dp_addr = o_tdc_rd_addr;
      dp_rise = o_rise_data;
    end

    if (o_wr_en) begin
      wr_t e;
      n_wr++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", {o_wr_addr, o_wr_data}, 64'h0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", o_wr_addr, e.addr);
        check("wr_data", o_wr_data, e.data);
      end
    end

    if (prev_done) check("busy_drop", o_busy, 1'b0);
    if (o_frame_done) begin
      n_done++;
      done_cyc = cyc;
      check("busy_at_done", o_busy, 1'b1);
    end
    prev_done = o_frame_done;
  end

  task automatic pulse_start(input logic [ADDR_W-1:0] f, input logic [ADDR_W-1:0] l,
                             input bit record);
    @(negedge i_clk_50m);
    i_addr_first = f;
    i_addr_last  = l;
    i_start      = 1'b1;
    if (record) start_cyc = cyc;
    @(negedge i_clk_50m);
    i_start      = 1'b0;
    // Bounds must have been latched; scramble them.
    i_addr_first = 11'($urandom);
    i_addr_last  = 11'($urandom);
  endtask

  task automatic wait_done(input int d0, input int budget);
    int k = 0;
    while (n_done == d0 && k < budget) begin
      @(posedge i_clk_50m);
      k++;
    end
    check("frame_done_seen", n_done != d0, 1'b1);
  endtask

  task automatic run_frame(input logic [ADDR_W-1:0] f, input logic [ADDR_W-1:0] l,
                           input int lat, input int exp_cnt, input bit disturb);
    int w0, r0, d0;
    wr_t e;
    dp_lat = lat;
    for (int a = int'(f); a <= int'(l); a++) begin
      e.addr = 11'(a);
      e.data = (dead_en && 11'(a) == dead_addr) ? 16'hFFFF : ram_f(11'(a)) + 16'd1;
      exp_q.push_back(e);
    end
    w0 = n_wr; r0 = n_rd; d0 = n_done;
    frame_pens = 0;
    if (disturb) stray_cnt = 2;
    pulse_start(f, l, 1'b1);
    if (disturb) begin
      repeat (10) @(negedge i_clk_50m);
      pulse_start(11'd0, 11'd2047, 1'b0);
    end
    wait_done(d0, (exp_cnt + 1) * (lat + TIMEOUT + 10) + 20);
    repeat (2) @(negedge i_clk_50m);
    check("frame_done_count", n_done - d0, 1);
    check("write_count", n_wr - w0, exp_cnt);
    check("read_count", n_rd - r0, exp_cnt);
    check("sample_cnt", o_sample_cnt, exp_cnt);
    check("scoreboard_empty", exp_q.size(), 0);
    check("busy_after", o_busy, 1'b0);
    if (exp_cnt == 0) check("empty_done_cyc", done_cyc, start_cyc + 2);
    exp_q.delete();
  endtask

  typedef struct {
    logic [ADDR_W-1:0] first;
    logic [ADDR_W-1:0] last;
    int                lat;
    int                exp_cnt;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int d0, w0, k;
    wr_t e;
    vecs[0] = '{11'd10,   11'd12,   14, 3};
    vecs[1] = '{11'd2047, 11'd2047, 3,  1};
    vecs[2] = '{11'd5,    11'd4,    6,  0};
    vecs[3] = '{11'd0,    11'd0,    1,  1};
    vecs[4] = '{11'd100,  11'd103,  2,  4};
    vecs[5] = '{11'd2040, 11'd2047, 1,  8};

    repeat (3) @(negedge i_clk_50m);
    check("rst_flags", {o_busy, o_frame_done, o_ram_rd_en, o_process_en, o_wr_en,
                        o_err_timeout}, 6'b0);
    check("rst_addrs", {o_ram_rd_addr, o_tdc_rd_addr, o_wr_addr, o_sample_cnt}, 64'h0);
    check("rst_data", {o_rise_data, o_wr_data}, 64'h0);
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk_50m);

    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].first, vecs[i].last, vecs[i].lat, vecs[i].exp_cnt, 1'b0);
    end

    // Re-pulsed start and stray dones during RD must not disturb the frame.
    run_frame(11'd20, 11'd22, 8, 3, 1'b1);
    check("no_timeout_flag", o_err_timeout, 1'b0);

    // Reset during the second sample's wait aborts the frame silently.
    dp_lat = 6;
    e.addr = 11'd30;
    e.data = ram_f(11'd30) + 16'd1;
    exp_q.push_back(e);
    frame_pens = 0;
    d0 = n_done;
    w0 = n_wr;
    pulse_start(11'd30, 11'd33, 1'b1);
    k = 0;
    while (frame_pens < 2 && k < 200) begin
      @(posedge i_clk_50m);
      k++;
    end
    check("second_launch_seen", frame_pens, 2);
    repeat (2) @(negedge i_clk_50m);
    i_rst_n = 1'b0;
    @(negedge i_clk_50m);
    check("midrst_flags", {o_busy, o_frame_done, o_ram_rd_en, o_process_en, o_wr_en,
                           o_err_timeout}, 6'b0);
    check("midrst_addrs", {o_ram_rd_addr, o_tdc_rd_addr, o_wr_addr, o_sample_cnt}, 64'h0);
    check("midrst_data", {o_rise_data, o_wr_data}, 64'h0);
    @(negedge i_clk_50m);
    i_rst_n = 1'b1;
    repeat (30) @(negedge i_clk_50m);
    check("midrst_no_done", n_done - d0, 0);
    check("midrst_writes", n_wr - w0, 1);
    check("midrst_scoreboard", exp_q.size(), 0);
    exp_q.delete();
    run_frame(11'd40, 11'd41, 3, 2, 1'b0);

`ifdef TDC_CORR_TIMEOUT_EN
    dead_en = 1'b1;
    dead_addr = 11'd7;
    run_frame(11'd6, 11'd8, 4, 3, 1'b0);
    check("timeout_flag_set", o_err_timeout, 1'b1);
    dead_en = 1'b0;
    run_frame(11'd1, 11'd1, 2, 1, 1'b0);
    check("timeout_flag_cleared", o_err_timeout, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tdc_corr_sched.md
TDC_CORR_SCHED -- requirements
Module: tdc_corr_sched

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, TDC sample address width.
REQ-002 SHALL have parameter DATA_W, default 16, rise/corrected data width.
REQ-003 SHALL have parameter TIMEOUT, default 31, done-wait limit in cycles (used only with TDC_CORR_TIMEOUT_EN).
REQ-004 i_clk_50m  in  1  sole clock; all logic on rising edge.
REQ-005 i_rst_n  in  1  synchronous, active-low reset.
REQ-006 i_start  in  1  one-cycle pulse; begins a correction frame.
REQ-007 i_addr_first / i_addr_last  in  ADDR_W  inclusive frame bounds; sampled on accepted i_start.
REQ-008 o_busy  out  1  high from accepted start through the frame_done cycle.
REQ-009 o_frame_done  out  1  one-cycle pulse at frame end.
REQ-010 o_ram_rd_en / o_ram_rd_addr  out  1 / ADDR_W  rise-data RAM read; data returns 1 cycle later on i_ram_rd_data (DATA_W).
REQ-011 o_tdc_rd_addr / o_rise_data  out  ADDR_W / DATA_W  operands to the correction datapath.
REQ-012 o_process_en  out  1  one-cycle launch pulse to the datapath.
REQ-013 i_process_done / i_process_data  in  1 / DATA_W  datapath completion pulse and result.
REQ-014 o_wr_en / o_wr_addr / o_wr_data  out  1 / ADDR_W / DATA_W  corrected-result write port.
REQ-015 o_sample_cnt  out  ADDR_W+1  number of samples written in the current/last frame.
REQ-016 o_err_timeout  out  1  sticky timeout flag.

Function
REQ-017 FSM states SHALL be IDLE, RD, RD_WAIT, LAUNCH, WAIT_DONE, WRITE, NEXT, DONE.
REQ-018 IDLE: on i_start, latch bounds, set cur=first, clear o_sample_cnt and o_err_timeout, go RD; if first>last, go DONE directly (empty frame, no reads, no writes).
REQ-019 RD: o_ram_rd_en=1, o_ram_rd_addr=cur for exactly one cycle; go RD_WAIT.
REQ-020 RD_WAIT: register i_ram_rd_data into o_rise_data; go LAUNCH.
REQ-021 LAUNCH: o_process_en=1 for one cycle; go WAIT_DONE.
REQ-022 o_tdc_rd_addr=cur and o_rise_data SHALL remain stable from LAUNCH until WAIT_DONE exits.
REQ-023 WAIT_DONE: on i_process_done, register i_process_data, go WRITE; i_process_done in any other state SHALL be ignored.
REQ-024 WRITE: o_wr_en=1, o_wr_addr=cur, o_wr_data=registered result for one cycle; o_sample_cnt increments; go NEXT.
REQ-025 NEXT: if cur==last go DONE, else cur=cur+1 and go RD; cur SHALL never wrap (last=2^ADDR_W-1 ends on equality).
REQ-026 DONE: o_frame_done=1 for one cycle; go IDLE; o_busy drops the following cycle.
REQ-027 i_start while o_busy SHALL be ignored; it is not queued.
REQ-028 Per-sample cost SHALL be 5 cycles plus the datapath latency (cycles from o_process_en to i_process_done); consecutive o_process_en pulses SHALL be at least 5 cycles apart, which covers the datapath's return-to-wait interval.
REQ-029 First-sample o_process_en SHALL occur exactly 3 cycles after the accepted i_start.

Reset
REQ-030 While i_rst_n=0 at a clock edge: state=IDLE; all outputs 0 (o_busy, o_frame_done, o_ram_rd_en, o_process_en, o_wr_en, o_err_timeout low; all address, data, and count outputs 0).
REQ-031 Reset mid-frame SHALL abort the frame with no further writes and no o_frame_done pulse.

Configuration
REQ-032 With TDC_CORR_TIMEOUT_EN defined: a counter runs in WAIT_DONE; after TIMEOUT cycles without i_process_done, the block SHALL write all-ones data to cur, set o_err_timeout (sticky until next accepted start), and continue at NEXT. A done arriving in the same cycle as the timeout SHALL take priority as a normal completion.
REQ-033 Without TDC_CORR_TIMEOUT_EN: no counter exists, WAIT_DONE waits indefinitely, and o_err_timeout is tied 0.

Verification
REQ-034 Start with first=10, last=12; datapath model returns rise+1 after 14 cycles -> three writes to addresses 10, 11, 12 with correct data; o_sample_cnt=3; a single o_frame_done; process_en pulses 19 cycles apart.
REQ-035 first=last=2047 -> exactly one read/write at 2047, then DONE; no wrap to 0.
REQ-036 first=5, last=4 -> o_frame_done 2 cycles after start; zero reads, zero writes; o_sample_cnt=0.
REQ-037 i_start re-pulsed mid-frame plus a stray i_process_done during RD -> both ignored; write sequence unchanged.
REQ-038 With macro defined, TIMEOUT=31, datapath never responds at address 7 -> write 0xFFFF to 7, o_err_timeout=1, frame completes; next start clears the flag.
REQ-039 i_rst_n low during WAIT_DONE of sample 2 -> all outputs 0 next cycle; no o_frame_done; a new start then runs normally.
